wmc_phase_timer: RTL and testbench

Phase timer for the washing machine controller (WMC). It serves the WMC's T20START/T20DONE handshake: each start request loads a phase duration, counts it down in minutes derived from CLOCK, and returns a single-cycle T20DONE. The timer is restartable, abortable and load-size aware. It sits beside the WMC and is its only timing resource for the WASH, RINSE and DRY phases.

---
 rtl/wmc_pkg.sv | 23 ++
 rtl/wmc_tick_gen.sv | 42 ++++
 rtl/wmc_phase_timer.sv | 107 ++++++++++
 tb/tb_wmc_phase_timer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/wmc_pkg.sv
// wmc_pkg: state encoding and default phase lengths shared by the WMC and its phase timer.
// Latency: none, types and constants only.
// Backpressure: none.
package wmc_pkg;

  // PAUSED is only reachable when the timer is built with WMC_TIMER_PAUSE_EN.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } wmc_state_e;

  // Default phase lengths in minutes, shared with the WMC sequencer.
  localparam int unsigned WMC_DURATION_MIN  = 20;
  localparam int unsigned WMC_LARGE_EXT_MIN = 5;

  // A phase is in progress while counting or frozen.
  function automatic logic wmc_is_busy(input wmc_state_e s);
    return (s == ST_RUN) || (s == ST_PAUSED);
  endfunction

endpackage

// File: rtl/wmc_tick_gen.sv
// wmc_tick_gen: prescaler turning CLOCK edges into a one-cycle minute tick.
// Latency: tick_o is high combinationally on the enabled edge that wraps the prescaler.
// Backpressure: none; en_i low freezes the count, clr_i zeroes it and wins over en_i.
module wmc_tick_gen #(
  parameter int unsigned TICKS_PER_MIN = 3000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned   CW   = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_MIN - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The wrap edge is the minute tick, so the caller decrements on the same edge.
  assign tick_o = en_i && (cnt_q == LAST);

  // Next prescaler value: clear, wrap at the last tick of a minute, or count up.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Prescaler register; the WMC runs on the falling edge.
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wmc_phase_timer.sv
// wmc_phase_timer: WMC phase timer, loads a duration on T20START and pulses T20DONE when it expires.
// Latency: BUSY/MIN_LEFT valid one edge after start; T20DONE in the cycle after edge start+N*TICKS_PER_MIN.
// Backpressure: none; a start always restarts, ABORT always wins. WMC_TIMER_PAUSE_EN adds PAUSE/PAUSED.
module wmc_phase_timer
  import wmc_pkg::*;
#(
  parameter int unsigned TICKS_PER_MIN = 3000,
  parameter int unsigned DURATION      = WMC_DURATION_MIN,
  parameter int unsigned LARGE_EXT     = WMC_LARGE_EXT_MIN,
  parameter int unsigned MIN_W         = 5
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             T20START,
  input  logic             LARGE_DISP,
  input  logic             ABORT,
`ifdef WMC_TIMER_PAUSE_EN
  input  logic             PAUSE,
`endif
  output logic             T20DONE,
  output logic             BUSY,
  output logic [MIN_W-1:0] MIN_LEFT
);

  localparam logic [MIN_W-1:0] LOAD_REG   = MIN_W'(DURATION);
  localparam logic [MIN_W-1:0] LOAD_LARGE = MIN_W'(DURATION + LARGE_EXT);

  wmc_state_e       state_q, state_d;
  logic [MIN_W-1:0] min_left_q, min_left_d;
  logic             done_q;
  logic             pause_w;
  logic             cnt_clr;
  logic             cnt_en;
  logic             min_tick;

`ifdef WMC_TIMER_PAUSE_EN
  assign pause_w = PAUSE;
`else
  assign pause_w = 1'b0;
`endif

  // Abort and start both restart the minute boundary; counting only runs in an
  // active phase on edges that are neither overridden nor frozen.
  assign cnt_clr = ABORT || T20START;
  assign cnt_en  = wmc_is_busy(state_q) && !cnt_clr && !pause_w;

  wmc_tick_gen #(
    .TICKS_PER_MIN(TICKS_PER_MIN)
  ) u_tick_gen (
    .clk_i (CLOCK),
    .rst_i (RESET),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tick_o(min_tick)
  );

  // Next state and minute count, in priority order abort, start, pause, count.
  always_comb begin
    state_d    = state_q;
    min_left_d = min_left_q;
    if (ABORT) begin
      state_d    = ST_IDLE;
      min_left_d = '0;
    end else if (T20START) begin
      state_d    = ST_RUN;
      min_left_d = LARGE_DISP ? LOAD_LARGE : LOAD_REG;
    end else begin
      case (state_q)
        ST_RUN, ST_PAUSED: begin
`ifdef WMC_TIMER_PAUSE_EN
          state_d = pause_w ? ST_PAUSED : ST_RUN;
`else
          state_d = ST_RUN;
`endif
          if (min_tick) begin
            if (min_left_q != '0) begin
              min_left_d = min_left_q - 1'b1;
            end
            if (min_left_q == MIN_W'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, minute counter and the registered done pulse (high exactly while in DONE).
  always_ff @(negedge CLOCK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      min_left_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_left_q <= min_left_d;
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign T20DONE  = done_q;
  assign BUSY     = wmc_is_busy(state_q);
  assign MIN_LEFT = min_left_q;

endmodule

// File: tb/tb_wmc_phase_timer.sv
// tb_wmc_phase_timer: directed bench for wmc_phase_timer with a per-edge reference scoreboard.
// Latency: each step drives one falling edge and compares the outputs 1 time unit later.
// Backpressure: none.
module tb_wmc_phase_timer;

  localparam int TPM = 4;
  localparam int DUR = 3;
  localparam int EXT = 2;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [4:0] min;
  } exp_t;

  logic       CLOCK = 1'b1;
  logic       RESET;
  logic       T20START;
  logic       LARGE_DISP;
  logic       ABORT;
  logic       pause_s;
  logic       T20DONE;
  logic       BUSY;
  logic [4:0] MIN_LEFT;

  int   checks    = 0;
  int   failures  = 0;
  int   done_seen = 0;
  exp_t sb[$];

  // Reference model: a phase is N minutes = N*TPM counted edges since the start.
  bit m_active;
  bit m_done;
  int m_n;
  int m_elapsed;

  wmc_phase_timer #(
    .TICKS_PER_MIN(TPM),
    .DURATION     (DUR),
    .LARGE_EXT    (EXT),
    .MIN_W        (5)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .T20START  (T20START),
    .LARGE_DISP(LARGE_DISP),
    .ABORT     (ABORT),
`ifdef WMC_TIMER_PAUSE_EN
    .PAUSE     (pause_s),
`endif
    .T20DONE   (T20DONE),
    .BUSY      (BUSY),
    .MIN_LEFT  (MIN_LEFT)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic model_edge(input logic rst, input logic ab, input logic st,
                            input logic lg, input logic ps);
    logic pe;
    exp_t e;
`ifdef WMC_TIMER_PAUSE_EN
    pe = ps;
`else
    pe = ps & 1'b0;
`endif
    m_done = 1'b0;
    if (rst || ab) begin
      m_active  = 1'b0;
      m_n       = 0;
      m_elapsed = 0;
    end else if (st) begin
      m_active  = 1'b1;
      m_n       = lg ? DUR + EXT : DUR;
      m_elapsed = 0;
    end else if (m_active) begin
      if (!pe) m_elapsed++;
      if (m_elapsed == m_n * TPM) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
    e.busy = m_active;
    e.done = m_done;
    e.min  = m_active ? 5'(m_n - m_elapsed / TPM) : 5'd0;
    sb.push_back(e);
  endtask

  task automatic step(input logic rst, input logic ab, input logic st,
                      input logic lg, input logic ps, input string tag);
    exp_t e;
    RESET      = rst;
    ABORT      = ab;
    T20START   = st;
    LARGE_DISP = lg;
    pause_s    = ps;
    model_edge(rst, ab, st, lg, ps);
    @(negedge CLOCK);
    #1;
    if (T20DONE === 1'b1) done_seen++;
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL %s scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (BUSY === e.busy) else begin
        failures++;
        $error("FAIL %s BUSY observed=%0b expected=%0b", tag, BUSY, e.busy);
      end
      checks++;
      assert (T20DONE === e.done) else begin
        failures++;
        $error("FAIL %s T20DONE observed=%0b expected=%0b", tag, T20DONE, e.done);
      end
      checks++;
      assert (MIN_LEFT === e.min) else begin
        failures++;
        $error("FAIL %s MIN_LEFT observed=%0d expected=%0d", tag, MIN_LEFT, e.min);
      end
    end
  endtask

  task automatic idle(input int n, input logic lg, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, lg, 1'b0, tag);
  endtask

  task automatic check_done_count(input int exp_cnt, input string tag);
    checks++;
    assert (done_seen == exp_cnt) else begin
      failures++;
      $error("FAIL %s done_pulses observed=%0d expected=%0d", tag, done_seen, exp_cnt);
    end
    done_seen = 0;
  endtask

  initial begin
    RESET = 1'b1; ABORT = 1'b0; T20START = 1'b0; LARGE_DISP = 1'b0; pause_s = 1'b0;
    m_active = 1'b0; m_done = 1'b0; m_n = 0; m_elapsed = 0;

    // Reset for two edges, then quiet.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    idle(2, 1'b0, "idle_after_reset");
    done_seen = 0;

    // Regular phase: 3 minutes, done after edge +12.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "regular_start");
    idle(14, 1'b0, "regular_run");
    check_done_count(1, "regular");

    // Large phase with LARGE_DISP toggling mid-run.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "large_start");
    for (int i = 0; i < 22; i++) step(1'b0, 1'b0, 1'b0, 1'(i % 2), 1'b0, "large_run");
    check_done_count(1, "large");

    // Retrigger at edge +6: single done, 12 edges after the second start.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "retrig_start");
    idle(5, 1'b0, "retrig_first");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "retrig_restart");
    idle(14, 1'b0, "retrig_second");
    check_done_count(1, "retrigger");

    // Abort at edge +5: never a done pulse.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "abort_start");
    idle(4, 1'b0, "abort_run");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "abort_edge");
    idle(14, 1'b0, "abort_after");
    check_done_count(0, "abort");

    // Abort and start on the same edge: start dropped.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "abort_and_start");
    idle(3, 1'b0, "abort_and_start_after");
    check_done_count(0, "abort_and_start");

    // Start in the DONE cycle: pulse completes, new run ends 12 edges later.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "done_restart_start");
    idle(12, 1'b0, "done_restart_first");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "done_restart_in_done");
    idle(14, 1'b0, "done_restart_second");
    check_done_count(2, "start_in_done");

    // Reset mid-run: idle after one edge, no done pulse.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "reset_mid_start");
    idle(5, 1'b0, "reset_mid_run");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset_mid_edge");
    idle(14, 1'b0, "reset_mid_after");
    check_done_count(0, "reset_mid_run");

`ifdef WMC_TIMER_PAUSE_EN
    // Pause for 8 edges from +5: MIN_LEFT frozen at 2, done after edge +20.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "pause_start");
    idle(4, 1'b0, "pause_pre");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "pause_hold");
    idle(10, 1'b0, "pause_post");
    check_done_count(1, "pause");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
